// File: rtl/data_memory_bytelane.sv
// Byte-addressed little-endian 32-bit data memory with byte/half/word lanes and a reset clear engine.
// Define DMEM_REG_READ_EN to register load data and rvalid (1-cycle latency); default is combinational.
module data_memory_bytelane #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  we,
    input  logic                  re,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    output logic [31:0]           rdata,
    output logic                  rvalid,
    output logic                  ready,
    output logic                  misaligned
);
    localparam int unsigned WordAw = ADDR_WIDTH - 2;
    localparam int unsigned Depth  = 1 << WordAw;

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [WordAw-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_we;

    logic [WordAw-1:0] widx;
    logic              illegal;
    logic              st_en, ld_en;
    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ld_data;

    logic [31:0] mem [Depth];

    // ---------------------------------------------------------------- clear FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            StClear: begin
                if (!CLEAR_ON_RESET) begin
                    state_d = StRun;
                end else begin
                    clr_we    = ~reset;
                    clr_cnt_d = clr_cnt_q + WordAw'(1);
                    if (clr_cnt_q == {WordAw{1'b1}}) begin
                        state_d = StRun;
                    end
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    assign ready = (state_q == StRun);

    // ---------------------------------------------------------------- request decode
    assign widx = addr[ADDR_WIDTH-1:2];

    always_comb begin
        illegal = 1'b0;
        case (size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = addr[0];
            2'b10:   illegal = (addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    assign misaligned = ready & (we | re) & illegal;
    assign st_en      = ready & we & ~illegal;
    assign ld_en      = ready & re & ~illegal;

    // Sub-word store data is replicated so every selected lane sees its own bytes.
    always_comb begin
        lane_en   = 4'b1111;
        lane_data = wdata;
        case (size)
            2'b00: begin
                lane_en   = 4'b0001 << addr[1:0];
                lane_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------- storage
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (st_en) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[widx][8*k +: 8] <= lane_data[8*k +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- load path
    assign word = mem[widx];

    always_comb begin
        byte_sel = word[7:0];
        case (addr[1:0])
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    assign half_sel = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_data = word;
        case (size)
            2'b00:   ld_data = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
            2'b01:   ld_data = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
            default: ld_data = word;
        endcase
    end

`ifdef DMEM_REG_READ_EN
    logic [31:0] rdata_q;
    logic        rvalid_q;

    // The read samples the array at the same edge a store updates it, so loads stay read-first.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ld_en;
            if (ld_en) begin
                rdata_q <= ld_data;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`else
    assign rvalid = ld_en;
    assign rdata  = ld_en ? ld_data : 32'h0;
`endif

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed scoreboard bench for data_memory_bytelane (ADDR_WIDTH=6, clear on reset).
// Handles both read modes; define DMEM_REG_READ_EN to match a registered-read build.
module tb_data_memory_bytelane;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [1:0]    size = 2'b10;
    logic          unsigned_ld = 1'b0;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          ready;
    logic          misaligned;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] last_rd = '0;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } exp_t;

    exp_t sb_q[$];

    data_memory_bytelane #(
        .ADDR_WIDTH    (AW),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .re         (re),
        .size       (size),
        .unsigned_ld(unsigned_ld),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .ready      (ready),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_read(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, " rvalid"}, {31'b0, rvalid}, {31'b0, e.v});
        check({tag, " rdata"}, rdata, e.d);
    endtask

    // One request cycle, driven from a negedge; returns at the next negedge.
    task automatic step(input string tag, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic w, input logic r, input logic [1:0] sz, input logic u,
                        input logic ev, input logic [31:0] ed, input logic em);
        exp_t e;
        addr = a; wdata = wd; we = w; re = r; size = sz; unsigned_ld = u;
        #1;
        check({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, em});
        e.v = ev;
`ifdef DMEM_REG_READ_EN
        e.d = ev ? ed : last_rd;
`else
        e.d = ev ? ed : 32'h0;
`endif
        if (ev) last_rd = ed;
        sb_q.push_back(e);
`ifndef DMEM_REG_READ_EN
        compare_read(tag);
`endif
        @(posedge clk);
        #1;
`ifdef DMEM_REG_READ_EN
        compare_read(tag);
`endif
        we = 1'b0;
        re = 1'b0;
        @(negedge clk);
    endtask

    task automatic store(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic em);
        step(tag, a, d, 1'b1, 1'b0, sz, 1'b0, 1'b0, 32'h0, em);
    endtask

    task automatic load(input string tag, input logic [AW-1:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] exp);
        step(tag, a, 32'h0, 1'b0, 1'b1, sz, u, 1'b1, exp, 1'b0);
    endtask

    // Counts cycles from reset release until ready rises; expects a full 16-word clear.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n), 32'd16);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        @(negedge clk);
        check("reset ready", {31'b0, ready}, 32'h0);
        check("reset rvalid", {31'b0, rvalid}, 32'h0);
        check("reset misaligned", {31'b0, misaligned}, 32'h0);
        check("reset rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        wait_ready("clear_len");

        for (int i = 0; i < 16; i++) begin
            load("lw_zero", AW'(4 * i), 2'b10, 1'b0, 32'h0);
        end

        // Sign / zero extension
        store("sw_10", 6'h10, 32'h8000_7F80, 2'b10, 1'b0);
        load("lb_10", 6'h10, 2'b00, 1'b0, 32'hFFFF_FF80);
        load("lbu_10", 6'h10, 2'b00, 1'b1, 32'h0000_0080);
        load("lh_12", 6'h12, 2'b01, 1'b0, 32'hFFFF_8000);
        load("lhu_12", 6'h12, 2'b01, 1'b1, 32'h0000_8000);
        load("lw_10_uns", 6'h10, 2'b10, 1'b1, 32'h8000_7F80);

        // Lane merging
        store("sw_20", 6'h20, 32'h1122_3344, 2'b10, 1'b0);
        store("sb_21", 6'h21, 32'h0000_00AA, 2'b00, 1'b0);
        store("sh_22", 6'h22, 32'h0000_BEEF, 2'b01, 1'b0);
        load("lw_20", 6'h20, 2'b10, 1'b0, 32'hBEEF_AA44);
        store("sb_3f", 6'h3F, 32'h0000_007F, 2'b00, 1'b0);
        load("lb_3f", 6'h3F, 2'b00, 1'b0, 32'h0000_007F);
        load("lh_3e", 6'h3E, 2'b01, 1'b0, 32'h0000_7F00);
        load("lw_3c", 6'h3C, 2'b10, 1'b0, 32'h7F00_0000);

        // Misaligned / illegal
        store("sh_05", 6'h05, 32'h0000_FFFF, 2'b01, 1'b1);
        store("sw_06", 6'h06, 32'hFFFF_FFFF, 2'b10, 1'b1);
        store("sb_size3", 6'h04, 32'hFFFF_FFFF, 2'b11, 1'b1);
        load("lw_04", 6'h04, 2'b10, 1'b0, 32'h0);
        step("ld_size3", 6'h08, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 1'b1);
        step("lh_05", 6'h05, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 1'b1);

        // Read-first on same-cycle store and load
        step("swlw_30", 6'h30, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0);
        load("lw_30", 6'h30, 2'b10, 1'b0, 32'hDEAD_BEEF);

        // Reset mid-clear restarts the clear; requests during clear are ignored
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        step("ign_clear", 6'h31, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready("reclear_len");
        load("lw_30_clr", 6'h30, 2'b10, 1'b0, 32'h0);
        load("lw_20_clr", 6'h20, 2'b10, 1'b0, 32'h0);
        load("lw_10_clr", 6'h10, 2'b10, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
